// File: rtl/pipelined_prefix_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_prefix_adder: elastic Sklansky adder/subtractor, ALU flags.      |
// | Optional signed saturation: define PREFIX_ADDER_SAT_EN.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipelined_prefix_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int MID    = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             a_msb;
    logic             c0;
`ifdef PREFIX_ADDER_SAT_EN
    logic             sat;
`endif
  } stage_t;

  // Prefix level l is evaluated in the gap feeding rank level_gap(l)+1.
  function automatic int level_gap(input int l);
    return ((l - 1) * STAGES) / LEVELS;
  endfunction

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_src_valid;
  logic              w_chain;
  logic              w_accept;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c0;
  stage_t            w_first;
  stage_t            w_out   [STAGES];
  stage_t            r_stage [MID];
  stage_t            w_last;
  logic [WIDTH-1:0]  w_raw;
  logic [WIDTH-1:0]  w_final;
  logic              w_cout;
  logic              w_ovf;
  logic [WIDTH-1:0]  r_result;
  logic              r_cout;
  logic              r_ovf;
  logic              r_neg;
  logic              r_zero;

  // Carry-in is folded into bit 0's generate so the tree yields c[i+1] = G[i:0].
  always_comb begin
    w_b_eff        = op[0] ? ~b : b;
    w_c0           = op[1] ? cin : op[0];
    w_first        = '0;
    w_first.x      = a ^ w_b_eff;
    w_first.g      = a & w_b_eff;
    w_first.p      = a | w_b_eff;
    w_first.g[0]   = w_first.g[0] | (w_first.p[0] & w_c0);
    w_first.a_msb  = a[WIDTH-1];
    w_first.c0     = w_c0;
`ifdef PREFIX_ADDER_SAT_EN
    w_first.sat    = sat;
`endif
  end

`ifndef PREFIX_ADDER_SAT_EN
  logic w_unused_sat;
  assign w_unused_sat = sat;
`endif

  always_comb begin
    for (int j = 0; j < STAGES; j++) begin
      w_out[j] = (j == 0) ? w_first : r_stage[(j == 0) ? 0 : j - 1];
      for (int l = 1; l <= LEVELS; l++) begin
        if (level_gap(l) == j) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (((i >> (l - 1)) & 1) == 1) begin
              w_out[j].g[i] = w_out[j].g[i] |
                              (w_out[j].p[i] & w_out[j].g[((i >> (l - 1)) << (l - 1)) - 1]);
              w_out[j].p[i] = w_out[j].p[i] & w_out[j].p[((i >> (l - 1)) << (l - 1)) - 1];
            end
          end
        end
      end
    end
  end

  assign w_last = w_out[STAGES-1];
  assign w_raw  = w_last.x ^ {w_last.g[WIDTH-2:0], w_last.c0};
  assign w_cout = w_last.g[WIDTH-1];
  assign w_ovf  = (w_last.a_msb == (w_last.x[WIDTH-1] ^ w_last.a_msb)) &&
                  (w_raw[WIDTH-1] != w_last.a_msb);

  always_comb begin
    w_final = w_raw;
`ifdef PREFIX_ADDER_SAT_EN
    if (w_last.sat && w_ovf) begin
      w_final = w_last.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // A rank loads when it or any rank downstream of it has a free slot.
  always_comb begin
    w_chain = out_ready;
    w_load  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_chain   = w_chain | ~r_valid[k];
      w_load[k] = w_chain;
    end
  end

  assign in_ready    = rst_n & w_load[0] & ~flush;
  assign w_accept    = in_valid & in_ready;
  assign w_src_valid = STAGES'({r_valid, w_accept});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= (w_load & w_src_valid) | (~w_load & r_valid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MID; k++) begin
        r_stage[k] <= '0;
      end
    end else if (!flush) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        if (w_load[k] && w_src_valid[k]) begin
          r_stage[k] <= w_out[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (!flush && w_load[STAGES-1] && w_src_valid[STAGES-1]) begin
      r_result <= w_final;
      r_cout   <= w_cout;
      r_ovf    <= w_ovf;
      r_neg    <= w_final[WIDTH-1];
      r_zero   <= (w_final == '0);
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign negative  = r_neg;
  assign zero      = r_zero;

endmodule
`default_nettype wire
